// File: rtl/player_missile_object.sv
// Player missile sprite: launches from the player's centre on fire, climbs
// SPEED pixels per frame, retires on collision or at the top of the screen.
// Drawing outputs are registered one clock after the pixel coordinates.
// Optional feature macro: MISSILE_COOLDOWN_EN adds a post-retire lockout
// of COOLDOWN_FRAMES frames before the next launch is accepted.
module player_missile_object #(
  parameter int         MISSILE_W   = 4,
  parameter int         MISSILE_H   = 16,
  parameter int         PLAYER_W    = 32,
  parameter int         SPEED       = 8,
  parameter logic [7:0] COLOR       = 8'hFC,
`ifdef MISSILE_COOLDOWN_EN
  parameter logic [7:0] TRANSPARENT = 8'hFF,
  parameter int         COOLDOWN_FRAMES = 15
`else
  parameter logic [7:0] TRANSPARENT = 8'hFF
`endif
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        fire,
  input  logic        collision,
  input  logic [10:0] playerX,
  input  logic [10:0] playerY,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic        missileActive,
  output logic [10:0] missileX,
  output logic [10:0] missileY
);

  localparam logic [10:0] SPEED_V   = 11'(SPEED);
  localparam logic [10:0] MH_V      = 11'(MISSILE_H);
  localparam logic [10:0] X_OFS     = 11'(PLAYER_W/2 - MISSILE_W/2);
  localparam logic [11:0] MW_EXT    = 12'(MISSILE_W);
  localparam logic [11:0] MH_EXT    = 12'(MISSILE_H);

`ifdef MISSILE_COOLDOWN_EN
  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;
  localparam state_t EXIT_ST = COOLDOWN;
  localparam int CD_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  logic [CD_W-1:0] cdCnt;
`else
  typedef enum logic [1:0] {IDLE, FLYING} state_t;
  localparam state_t EXIT_ST = IDLE;
`endif

  state_t state, nstate;
  logic   firePending, hitFlag;
  logic   launch, exitFly, move;
  logic   inX, inY, drawNext;

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= nstate;
  end

  // Next-state: launch on frame with a pending/current fire, retire on frame
  // when hit or when the next step would cross row 0
  always_comb begin
    nstate = state;
    case (state)
      IDLE:     if (startOfFrame && (firePending || fire)) nstate = FLYING;
      FLYING:   if (startOfFrame && (hitFlag || collision || missileY < SPEED_V))
                  nstate = EXIT_ST;
`ifdef MISSILE_COOLDOWN_EN
      COOLDOWN: if (startOfFrame && cdCnt == '0) nstate = IDLE;
`endif
      default:  nstate = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    missileActive = (state == FLYING);
  end

  assign launch  = (state == IDLE) && (nstate == FLYING);
  assign exitFly = (state == FLYING) && (nstate != FLYING);
  assign move    = (state == FLYING) && startOfFrame && !exitFly;

  // Missile position: set at launch, climbs once per frame, held on retire
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      missileX <= '0;
      missileY <= '0;
    end else if (launch) begin
      missileX <= playerX + X_OFS;
      missileY <= (playerY < MH_V) ? 11'd0 : playerY - MH_V;
    end else if (move) begin
      missileY <= missileY - SPEED_V;
    end
  end

  // Fire is latched only while idle; anything during flight is dropped
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)             firePending <= 1'b0;
    else if (state != IDLE)  firePending <= 1'b0;
    else if (launch)         firePending <= 1'b0;
    else if (fire)           firePending <= 1'b1;
  end

  // Hit is remembered until the frame boundary retires the missile
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                             hitFlag <= 1'b0;
    else if (state == FLYING && !exitFly)    hitFlag <= hitFlag | collision;
    else                                     hitFlag <= 1'b0;
  end

`ifdef MISSILE_COOLDOWN_EN
  // Lockout counter: loaded on retire, counts frames down to zero
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                 cdCnt <= '0;
    else if (exitFly)            cdCnt <= CD_W'(COOLDOWN_FRAMES);
    else if (state == COOLDOWN && startOfFrame && cdCnt != '0)
                                 cdCnt <= cdCnt - 1'b1;
  end
`endif

  // Bounds checks in 12 bits so a missile near X=2047 does not wrap
  assign inX = (pixelX >= missileX) && ({1'b0, pixelX} < ({1'b0, missileX} + MW_EXT));
  assign inY = (pixelY >= missileY) && ({1'b0, pixelY} < ({1'b0, missileY} + MH_EXT));
  assign drawNext = (state == FLYING) && !hitFlag && !collision && inX && inY;

  // Registered pixel output
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawingRequest <= 1'b0;
      RGBout         <= TRANSPARENT;
    end else begin
      drawingRequest <= drawNext;
      RGBout         <= drawNext ? COLOR : TRANSPARENT;
    end
  end

endmodule

// File: tb/tb_player_missile_object.sv
// Bench for player_missile_object: directed scenarios plus randomized
// traffic compared against a frame-level behavioural model.
module tb_player_missile_object;

  localparam int MW = 4, MH = 16, PW = 32, SPD = 8;
`ifdef MISSILE_COOLDOWN_EN
  localparam int CF = 15;
  localparam bit COOL = 1'b1;
`else
  localparam int CF = 0;
  localparam bit COOL = 1'b0;
`endif

  logic        clk, resetN, sof, fire, col;
  logic [10:0] plx, ply, px, py;
  logic        draw, act;
  logic [7:0]  rgb;
  logic [10:0] mx, my;

  int checks = 0, errors = 0;

  // Model: 0 idle, 1 flying, 2 cooldown
  int m_st, m_x, m_y, m_pend, m_hit, m_cnt, m_draw;

  player_missile_object dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .fire(fire),
    .collision(col), .playerX(plx), .playerY(ply), .pixelX(px), .pixelY(py),
    .drawingRequest(draw), .RGBout(rgb), .missileActive(act),
    .missileX(mx), .missileY(my)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_st = 0; m_x = 0; m_y = 0; m_pend = 0; m_hit = 0; m_cnt = 0; m_draw = 0;
  endtask

  // One clock: model the frame rules from current inputs, then advance
  task automatic tick();
    int n_st, n_x, n_y, n_pend, n_hit, n_cnt, n_draw;
    bit exit_now;
    n_st = m_st; n_x = m_x; n_y = m_y; n_pend = m_pend; n_hit = m_hit; n_cnt = m_cnt;
    exit_now = 0;
    n_draw = (m_st == 1) && !m_hit && !col &&
             (int'(px) >= m_x) && (int'(px) < m_x + MW) &&
             (int'(py) >= m_y) && (int'(py) < m_y + MH);
    if (m_st == 0) begin
      if (sof && (m_pend != 0 || fire)) begin
        n_st = 1;
        n_x = (int'(plx) + PW/2 - MW/2) % 2048;
        n_y = (int'(ply) < MH) ? 0 : int'(ply) - MH;
        n_pend = 0;
      end else if (fire) n_pend = 1;
    end else if (m_st == 1) begin
      n_pend = 0;
      if (sof) begin
        if (m_hit != 0 || col || m_y < SPD) exit_now = 1;
        else n_y = m_y - SPD;
      end else if (col) n_hit = 1;
      if (exit_now) begin
        n_st = COOL ? 2 : 0;
        n_hit = 0;
        n_cnt = CF;
      end
    end else begin
      n_pend = 0;
      if (sof) begin
        if (m_cnt == 0) n_st = 0;
        else n_cnt = m_cnt - 1;
      end
    end
    @(posedge clk); #1;
    m_st = n_st; m_x = n_x; m_y = n_y; m_pend = n_pend; m_hit = n_hit;
    m_cnt = n_cnt; m_draw = n_draw;
  endtask

  task automatic frame();
    sof = 1; tick(); sof = 0; tick();
  endtask

  // Bring the missile back to idle; bounded frame count
  task automatic go_idle();
    fire = 0;
    col = 1; tick(); col = 0;
    for (int i = 0; i < 40 && m_st != 0; i++) frame();
    checks++;
    if (act !== 1'b0 || m_st != 0) begin
      errors++;
      $display("FAIL go_idle: active=%0d model_state=%0d required 0/0", act, m_st);
    end
  endtask

  task automatic test_reset();
    resetN = 0; sof = 0; fire = 0; col = 0;
    plx = 0; ply = 0; px = 0; py = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({draw, rgb, act, mx, my} !== {1'b0, 8'hFF, 1'b0, 11'd0, 11'd0}) begin
      errors++;
      $display("FAIL reset: draw=%0d rgb=%h act=%0d x=%0d y=%0d required 0 ff 0 0 0",
               draw, rgb, act, mx, my);
    end
    resetN = 1;
    tick();
  endtask

  task automatic test_launch();
    plx = 300; ply = 440;
    fire = 1; tick(); fire = 0; tick();
    sof = 1; tick(); sof = 0;
    checks++;
    if (mx !== 11'd314 || my !== 11'd424 || act !== 1'b1) begin
      errors++;
      $display("FAIL launch: x=%0d y=%0d act=%0d required 314 424 1", mx, my, act);
    end
  endtask

  task automatic test_move_draw();
    tick();
    repeat (3) frame();
    checks++;
    if (my !== 11'd400) begin
      errors++;
      $display("FAIL move: y=%0d required 400", my);
    end
    px = 315; py = 405; tick();
    checks++;
    if (draw !== 1'b1 || rgb !== 8'hFC) begin
      errors++;
      $display("FAIL draw_inside: draw=%0d rgb=%h required 1 fc", draw, rgb);
    end
    px = 318; tick();
    checks++;
    if (draw !== 1'b0 || rgb !== 8'hFF) begin
      errors++;
      $display("FAIL draw_right_edge: draw=%0d rgb=%h required 0 ff", draw, rgb);
    end
  endtask

  task automatic test_top_boundary();
    go_idle();
    ply = 21; fire = 1; sof = 1; tick(); fire = 0; sof = 0;
    checks++;
    if (my !== 11'd5 || act !== 1'b1) begin
      errors++;
      $display("FAIL launch_y5: y=%0d act=%0d required 5 1", my, act);
    end
    tick(); sof = 1; tick(); sof = 0;
    checks++;
    if (act !== 1'b0 || my !== 11'd5) begin
      errors++;
      $display("FAIL top_exit: act=%0d y=%0d required 0 5", act, my);
    end
    go_idle();
    ply = 10; fire = 1; sof = 1; tick(); fire = 0; sof = 0;
    checks++;
    if (my !== 11'd0 || act !== 1'b1) begin
      errors++;
      $display("FAIL launch_clamp: y=%0d act=%0d required 0 1", my, act);
    end
    go_idle();
  endtask

  task automatic test_collision();
    ply = 216; fire = 1; sof = 1; tick(); fire = 0; sof = 0;
    px = 315; py = 205; tick();
    checks++;
    if (my !== 11'd200 || draw !== 1'b1) begin
      errors++;
      $display("FAIL pre_hit: y=%0d draw=%0d required 200 1", my, draw);
    end
    col = 1; tick(); col = 0;
    checks++;
    if (draw !== 1'b0 || rgb !== 8'hFF) begin
      errors++;
      $display("FAIL hit_suppress: draw=%0d rgb=%h required 0 ff", draw, rgb);
    end
    tick(); tick();
    checks++;
    if (draw !== 1'b0 || act !== 1'b1) begin
      errors++;
      $display("FAIL hit_hold: draw=%0d act=%0d required 0 1", draw, act);
    end
    sof = 1; tick(); sof = 0;
    checks++;
    if (act !== 1'b0) begin
      errors++;
      $display("FAIL hit_retire: act=%0d required 0", act);
    end
    go_idle();
    fire = 1; sof = 1; tick(); fire = 0; sof = 0; tick();
    col = 1; sof = 1; tick(); col = 0; sof = 0;
    checks++;
    if (act !== 1'b0 || my !== 11'd200) begin
      errors++;
      $display("FAIL hit_same_cycle: act=%0d y=%0d required 0 200", act, my);
    end
    go_idle();
  endtask

  task automatic test_fire_hold();
    int cnt;
    ply = 40; fire = 1; sof = 1; tick(); sof = 0; tick();
    for (int i = 0; i < 3; i++) begin
      frame();
      checks++;
      if (act !== 1'b1 || int'(my) != 16 - 8*i || int'(my) != m_y) begin
        errors++;
        $display("FAIL fire_hold_fly%0d: act=%0d y=%0d required 1 %0d", i, act, my, 16 - 8*i);
      end
    end
    sof = 1; tick(); sof = 0; tick();
    checks++;
    if (act !== 1'b0) begin
      errors++;
      $display("FAIL fire_hold_retire: act=%0d required 0", act);
    end
    cnt = 0;
    while (act !== 1'b1 && cnt < 40) begin
      frame();
      cnt++;
    end
    checks++;
    if (cnt != (COOL ? CF + 2 : 1)) begin
      errors++;
      $display("FAIL fire_hold_relaunch: frames=%0d required %0d", cnt, COOL ? CF + 2 : 1);
    end
    go_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      sof  = ($urandom_range(0, 7) == 0);
      fire = ($urandom_range(0, 3) == 0);
      col  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) begin
        plx = 11'($urandom_range(2030, 2047));
        ply = 11'($urandom_range(0, 480));
      end else if ($urandom_range(0, 9) == 0) begin
        plx = 11'($urandom_range(0, 2047));
        ply = 11'($urandom_range(0, 480));
      end
      if (m_st == 1 && $urandom_range(0, 1) == 1) begin
        px = 11'((m_x + 2047 + $urandom_range(0, MW + 1)) % 2048);
        py = 11'((m_y + 2047 + $urandom_range(0, MH + 1)) % 2048);
      end else begin
        px = 11'($urandom_range(0, 2047));
        py = 11'($urandom_range(0, 2047));
      end
      tick();
      checks++;
      if (draw !== 1'(m_draw) || rgb !== (m_draw != 0 ? 8'hFC : 8'hFF) ||
          act !== 1'(m_st == 1) || mx !== 11'(m_x) || my !== 11'(m_y)) begin
        errors++;
        $display("FAIL random_c%0d: draw=%0d rgb=%h act=%0d x=%0d y=%0d required %0d %h %0d %0d %0d",
                 i, draw, rgb, act, mx, my, m_draw, (m_draw != 0 ? 8'hFC : 8'hFF),
                 (m_st == 1), m_x, m_y);
      end
    end
    sof = 0; fire = 0; col = 0;
    go_idle();
  endtask

  task automatic test_async_reset();
    plx = 500; ply = 300; px = 514; py = 290;
    fire = 1; sof = 1; tick(); fire = 0; sof = 0; tick();
    checks++;
    if (act !== 1'b1 || draw !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: act=%0d draw=%0d required 1 1", act, draw);
    end
    #2 resetN = 0;
    #1;
    model_reset();
    checks++;
    if ({draw, rgb, act, mx, my} !== {1'b0, 8'hFF, 1'b0, 11'd0, 11'd0}) begin
      errors++;
      $display("FAIL async_reset: draw=%0d rgb=%h act=%0d x=%0d y=%0d required 0 ff 0 0 0",
               draw, rgb, act, mx, my);
    end
    @(posedge clk); #1;
    resetN = 1;
    sof = 1; tick(); sof = 0;
    checks++;
    if (act !== 1'b0) begin
      errors++;
      $display("FAIL no_carry_over: act=%0d required 0", act);
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_move_draw();
    test_top_boundary();
    test_collision();
    test_fire_hold();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
